// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM/WB slice.
//  wb_payload_t : write-back payload at the default widths (32-bit data, 5-bit index).
//  REG_ZERO     : index of the hard-wired zero register.
package pipe_pkg;
    localparam int DATA_W_DFLT     = 32;
    localparam int REG_ADDR_W_DFLT = 5;

    typedef struct packed {
        logic                       reg_write;
        logic                       mem_to_reg;
        logic [DATA_W_DFLT-1:0]     alu_result;
        logic [DATA_W_DFLT-1:0]     read_data;
        logic [REG_ADDR_W_DFLT-1:0] write_reg;
    } wb_payload_t;

    localparam logic [REG_ADDR_W_DFLT-1:0] REG_ZERO = '0;
endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer over a W-bit payload vector.
// The main entry drives the outputs. The skid entry absorbs one transfer
// that arrives while main is stalled.
// Ports:
//  clk, rst (sync, active high), flush (drop everything, ignore input)
//  in_valid/in_ready/in_data    : upstream side; in_ready is registered (= !skid_valid)
//  out_valid/out_ready/out_data : downstream side, driven straight from main registers
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_valid, skid_valid;
    logic [W-1:0] main_data, skid_data;
    logic         accept, consume;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign accept    = in_valid && in_ready && !flush;
    assign consume   = main_valid && out_ready;

    // Payload registers load only together with their valid bit. This keeps
    // held data stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || consume) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                // in_ready is low whenever skid is valid, so accept is
                // always 0 here. The branch is kept for generality.
                if (accept) begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with a valid/ready handshake, a 2-entry skid buffer
// and flush-to-bubble. It also contains the write-back data mux and the
// register-file write enable.
// Ports:
//  clk, rst (sync, active high), flush
//  in_valid/in_ready + reg_write_i, mem_to_reg_i, alu_result_i, read_data_i, write_reg_i
//  out_valid/out_ready + reg_write_o, write_reg_o, wb_data_o, rf_we_o
// wb_data_o and rf_we_o are decoded from the registered main entry. The only
// combinational input path is out_ready -> rf_we_o.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int ZERO_REG_RO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [DATA_W-1:0]     read_data_i,
    input  logic [REG_ADDR_W-1:0] write_reg_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write_o,
    output logic [REG_ADDR_W-1:0] write_reg_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  rf_we_o
);
    // Same layout as wb_payload_t, but sized by this instance's parameters.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     read_data;
        logic [REG_ADDR_W-1:0] write_reg;
    } payload_t;

    payload_t in_pl, main_pl;
    logic     wr_is_zero;

    assign in_pl = '{reg_write:  reg_write_i,
                     mem_to_reg: mem_to_reg_i,
                     alu_result: alu_result_i,
                     read_data:  read_data_i,
                     write_reg:  write_reg_i};

    pipe_skid_buf #(.W($bits(payload_t))) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_pl)
    );

    assign reg_write_o = main_pl.reg_write;
    assign write_reg_o = main_pl.write_reg;
    assign wb_data_o   = main_pl.mem_to_reg ? main_pl.read_data : main_pl.alu_result;

    // flush does not gate rf_we_o. A write consumed in the flush cycle
    // still completes.
    assign wr_is_zero  = (main_pl.write_reg == REG_ADDR_W'(REG_ZERO));
    assign rf_we_o     = out_valid && out_ready && main_pl.reg_write &&
                         !((ZERO_REG_RO != 0) && wr_is_zero);
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic        reg_write_i, mem_to_reg_i;
    logic [31:0] alu_result_i, read_data_i;
    logic [4:0]  write_reg_i;
    logic        out_valid, out_ready, reg_write_o, rf_we_o;
    logic [4:0]  write_reg_o;
    logic [31:0] wb_data_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic        rw;
        logic [31:0] wb;
        logic [4:0]  wr;
    } exp_t;
    exp_t q[$];

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_RO(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
        .alu_result_i(alu_result_i), .read_data_i(read_data_i), .write_reg_i(write_reg_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_write_o(reg_write_o), .write_reg_o(write_reg_o),
        .wb_data_o(wb_data_o), .rf_we_o(rf_we_o)
    );

    always #5 clk = ~clk;

    // Reference model: the queue holds main then skid, so out_valid = size>0
    // and in_ready = size<2. Stimulus is pushed when accepted and popped when consumed.
    always @(posedge clk) begin
        bit cons, acc;
        exp_t e;
        cons = (q.size() > 0) && out_ready;
        acc  = in_valid && (q.size() < 2) && !flush;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) begin
                e.rw = reg_write_i;
                e.wb = mem_to_reg_i ? read_data_i : alu_result_i;
                e.wr = write_reg_i;
                q.push_back(e);
            end
        end
    end

    // Compare the DUT outputs against the queue head on the falling edge.
    always @(negedge clk) begin
        bit ev, ewe;
        if (chk_en) begin
            ev  = (q.size() > 0);
            ewe = ev && out_ready && q[0].rw && (q[0].wr != 5'd0);
            checks++;
            if (out_valid !== ev) begin
                errors++;
                $display("FAIL sb_out_valid: got %0b expected %0b t=%0t", out_valid, ev, $time);
            end
            checks++;
            if (in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL sb_in_ready: got %0b expected %0b t=%0t", in_ready, q.size() < 2, $time);
            end
            checks++;
            if (rf_we_o !== ewe) begin
                errors++;
                $display("FAIL sb_rf_we: got %0b expected %0b t=%0t", rf_we_o, ewe, $time);
            end
            if (ev) begin
                checks++;
                if (wb_data_o !== q[0].wb || write_reg_o !== q[0].wr || reg_write_o !== q[0].rw) begin
                    errors++;
                    $display("FAIL sb_payload: got wb=%h wr=%0d rw=%0b expected wb=%h wr=%0d rw=%0b t=%0t",
                             wb_data_o, write_reg_o, reg_write_o, q[0].wb, q[0].wr, q[0].rw, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr);
        in_valid     = v;
        reg_write_i  = rw;
        mem_to_reg_i = m2r;
        alu_result_i = alu;
        read_data_i  = rd;
        write_reg_i  = wr;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        tick(); tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || rf_we_o !== 1'b0 || wb_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset: got ov=%0b ir=%0b we=%0b wb=%h expected 0 1 0 0",
                     out_valid, in_ready, rf_we_o, wb_data_o);
        end
        chk_en = 1'b1;
    endtask

    task automatic test_basic();
        tick();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h1234, 32'hDEAD, 5'd5);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h1234, 32'hDEAD, 5'd5);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || wb_data_o !== 32'h1234 || write_reg_o !== 5'd5 || rf_we_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_alu: got ov=%0b wb=%h wr=%0d we=%0b expected 1 1234 5 1",
                     out_valid, wb_data_o, write_reg_o, rf_we_o);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || wb_data_o !== 32'hDEAD || rf_we_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_mem: got ov=%0b wb=%h we=%0b expected 1 dead 1",
                     out_valid, wb_data_o, rf_we_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 5'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 5'd2);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || wb_data_o !== 32'hA || in_ready !== 1'b0 || rf_we_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: got ov=%0b wb=%h ir=%0b we=%0b expected 1 a 0 0",
                         out_valid, wb_data_o, in_ready, rf_we_o);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_data_o !== 32'hA || rf_we_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_a: got wb=%h we=%0b expected a 1", wb_data_o, rf_we_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || wb_data_o !== 32'hB || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_b: got ov=%0b wb=%h ir=%0b expected 1 b 1", out_valid, wb_data_o, in_ready);
        end
        tick(); tick();
        drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 5'd3);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || wb_data_o !== 32'hC) begin
            errors++;
            $display("FAIL bp_late_c: got ov=%0b wb=%h expected 1 c", out_valid, wb_data_o);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg: got ov=%0b we=%0b expected 1 0", out_valid, rf_we_o);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hA1, 32'h0, 5'd7);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hB2, 32'h0, 5'd8);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hF1F1, 32'h0, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got ov=%0b ir=%0b expected 0 1", out_valid, in_ready);
        end
        // Flush while there is room: the offered entry must still be dropped.
        drive(1'b1, 1'b1, 1'b0, 32'hA3, 32'h0, 5'd4);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hF2F2, 32'h0, 5'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_dropped: got ov=%0b wb=%h expected ov 0", out_valid, wb_data_o);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(99) < 50, 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 5'($urandom));
            out_ready = ($urandom_range(99) < 60);
            flush     = ($urandom_range(99) < 3);
            rst       = (i == 5000);
            tick();
            if (i == 5000) begin
                rst = 1'b0;
                drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
                flush = 1'b0;
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_reset: got ov=%0b ir=%0b expected 0 1", out_valid, in_ready);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        flush = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got ov=%0b qsize=%0d expected 0 0", out_valid, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_reg();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
